// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcode constants, 4-bit ALU codes and the funct3/funct7 to ALU mapping.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
  function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the I/S/B/U/J form from the opcode and sign-extends it to XLEN.
module imm_gen
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm;

  always_comb begin
    w_imm = '0;
    case (i_instr[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        w_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        w_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        w_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm = {i_instr[31:12], 12'b0};
      OPC_JAL:
        w_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm));

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, WB->ID bypass, load-use stall and the ID/EX register.
// Optional stall counter output enabled by defining ID_STALL_CNT_EN.
module id_stage
  import rv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            ex_flush,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            wb_we,
  input  logic [4:0]      wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_reg_we,
  output logic            ex_branch,
  output logic            ex_jump
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  logic            w_legal;
  logic [3:0]      w_alu_op;
  logic            w_alu_src;
  logic            w_mem_rd;
  logic            w_mem_wr;
  logic            w_reg_we;
  logic            w_branch;
  logic            w_jump;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_load;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;

  assign w_opc = if_instr[6:0];
  assign w_f3  = if_instr[14:12];
  assign w_rd  = if_instr[11:7];
  assign ra1   = if_instr[19:15];
  assign ra2   = if_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  always_comb begin
    w_legal   = 1'b1;
    w_alu_op  = ALU_ADD;
    w_alu_src = 1'b0;
    w_mem_rd  = 1'b0;
    w_mem_wr  = 1'b0;
    w_reg_we  = 1'b0;
    w_branch  = 1'b0;
    w_jump    = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opc)
      OPC_OP: begin
        w_alu_op  = alu_from_funct(w_f3, if_instr[30]);
        w_reg_we  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7[5] is part of the immediate except for shift-right
        w_alu_op  = alu_from_funct(w_f3, (w_f3 == 3'b101) && if_instr[30]);
        w_alu_src = 1'b1;
        w_reg_we  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        w_alu_src = 1'b1;
        w_mem_rd  = 1'b1;
        w_reg_we  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        w_alu_src = 1'b1;
        w_mem_wr  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        w_alu_op  = {1'b0, w_f3};
        w_branch  = 1'b1;
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        w_jump    = 1'b1;
        w_reg_we  = 1'b1;
      end
      OPC_JALR: begin
        w_alu_src = 1'b1;
        w_jump    = 1'b1;
        w_reg_we  = 1'b1;
        w_use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        w_alu_op  = ALU_PASSB;
        w_alu_src = 1'b1;
        w_reg_we  = 1'b1;
      end
      OPC_AUIPC: begin
        w_alu_src = 1'b1;
        w_reg_we  = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Regfile writes at the same edge ID/EX captures, so WB data must be forwarded here
  always_comb begin
    w_rs1_val = rd1;
    w_rs2_val = rd2;
    if (ra1 == 5'd0)
      w_rs1_val = '0;
    else if (wb_we && (wb_wa == ra1))
      w_rs1_val = wb_wd;
    if (ra2 == 5'd0)
      w_rs2_val = '0;
    else if (wb_we && (wb_wa == ra2))
      w_rs2_val = wb_wd;
  end

  assign stall = if_valid && ex_valid && ex_mem_rd && (ex_rd != 5'd0) &&
                 ((w_use_rs1 && (ex_rd == ra1)) || (w_use_rs2 && (ex_rd == ra2))) &&
                 !ex_flush;

  assign w_load = !ex_flush && !stall && if_valid && w_legal;

  // Data fields always advance; only valid and controls are squashed for bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= RESET_PC;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_alu_op  <= '0;
      ex_alu_src <= 1'b0;
      ex_mem_rd  <= 1'b0;
      ex_mem_wr  <= 1'b0;
      ex_reg_we  <= 1'b0;
      ex_branch  <= 1'b0;
      ex_jump    <= 1'b0;
    end else begin
      ex_valid   <= w_load;
      ex_pc      <= if_pc;
      ex_rs1_val <= w_rs1_val;
      ex_rs2_val <= w_rs2_val;
      ex_imm     <= w_imm;
      ex_rs1     <= ra1;
      ex_rs2     <= ra2;
      ex_rd      <= w_rd;
      ex_alu_op  <= w_load ? w_alu_op : 4'd0;
      ex_alu_src <= w_load && w_alu_src;
      ex_mem_rd  <= w_load && w_mem_rd;
      ex_mem_wr  <= w_load && w_mem_wr;
      ex_reg_we  <= w_load && w_reg_we && (w_rd != 5'd0);
      ex_branch  <= w_load && w_branch;
      ex_jump    <= w_load && w_jump;
    end
  end

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage RV32I pipeline; sits between the IF/ID register and EX, and drives the register file read ports.
- Decodes the instruction and generates the immediate and control bundle.
- Applies a WB→ID bypass, because the register file writes on posedge and reads combinationally.
- Detects load-use hazards, stalls, and registers everything into the ID/EX pipeline register.

Parameters:
XLEN, 32, data/PC width
RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-high
if_valid  in  1  IF/ID holds a real instruction
if_instr  in  32  instruction word from IF/ID
if_pc  in  XLEN  PC of if_instr
ex_flush  in  1  taken branch/jump resolved in EX; kill ID contents
ra1  out  5  regfile read address 1 = if_instr[19:15]
ra2  out  5  regfile read address 2 = if_instr[24:20]
rd1  in  XLEN  regfile read data 1
rd2  in  XLEN  regfile read data 2
wb_we  in  1  writeback enable (same signal as regfile we)
wb_wa  in  5  writeback address
wb_wd  in  XLEN  writeback data
stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rs1_val  out  XLEN  registered operand 1 (after bypass)
ex_rs2_val  out  XLEN  registered operand 2 (after bypass)
ex_imm  out  XLEN  registered sign-extended immediate
ex_rs1  out  5  registered rs1 (for EX forwarding)
ex_rs2  out  5  registered rs2
ex_rd  out  5  registered rd
ex_alu_op  out  4  ALU operation code
ex_alu_src  out  1  1 = ALU operand B is ex_imm
ex_mem_rd  out  1  load word
ex_mem_wr  out  1  store word
ex_reg_we  out  1  instruction writes rd
ex_branch  out  1  conditional branch; funct3 in ex_alu_op
ex_jump  out  1  JAL/JALR

Behaviour:
- Reset (async, rst=1): all ex_* outputs = 0, except ex_pc = RESET_PC. stall output is 0 whenever ex_valid=0, so it is 0 during and after reset.
- Decoded opcodes:
  - OP, OP-IMM, LOAD (LW), STORE (SW), BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode is illegal and decodes as a bubble: the loaded bundle has ex_valid=0 and all controls 0.
- Immediates: I, S, B, U, J forms, sign-extended to XLEN from instr[31]. B and J immediates have bit 0 = 0.
- ALU op selection:
  - OP: funct3 + funct7[5].
  - OP-IMM: funct3; funct7[5] is used only for SRAI.
  - LOAD, STORE, AUIPC, JAL, JALR: ADD.
  - LUI: PASSB.
  - BRANCH: ex_alu_op = {1'b0, funct3}, with ex_branch=1.
- alu_src = 1 for OP-IMM, LOAD, STORE, LUI, AUIPC, JALR.
- reg_we = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC; forced to 0 when rd=x0.
- Bypass (combinational):
  - rs1_val = (wb_we && wb_wa!=0 && wb_wa==ra1) ? wb_wd : rd1. Same rule for rs2.
  - x0 always reads 0.
- Source usage:
  - rs1 used by all decoded opcodes except LUI, AUIPC, JAL.
  - rs2 used only by OP, STORE, BRANCH.
- Load-use hazard: stall = if_valid && ex_valid && ex_mem_rd && ex_rd!=0 && ((rs1 used && ex_rd==ra1) || (rs2 used && ex_rd==ra2)) && !ex_flush.
- Pipeline register update each posedge, highest priority first:
  1. ex_flush → ex_valid<=0, controls<=0.
  2. stall → ex_valid<=0, controls<=0. This inserts exactly one bubble; IF holds, and the next cycle re-decodes the same instruction, whose hazard is now cleared.
  3. otherwise → load the decoded bundle; ex_valid <= if_valid && legal.
- No enable input: ID/EX advances every cycle (no downstream backpressure).
- Flush and stall in the same cycle: flush wins and stall=0, because the ID instruction is wrong-path.
- Latency: 1 cycle, if_instr → ex_* outputs.

Optional Feature:
- Macro ID_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits), reset to 0.
  - Increments on every cycle with stall=1.
  - Wraps from 32'hFFFF_FFFF to 0.
- When undefined: no port, no counter logic.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC);
  - the 4-bit ALU codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
- One natural sub-module, imm_gen: purely combinational, instr → XLEN immediate. All other logic stays in id_stage.

Test Plan:
- Decode addi x5,x0,-3 (32'hFFD00293), if_valid=1 → next cycle:
  - ex_valid=1, ex_rd=5, ex_imm=32'hFFFFFFFD;
  - ex_alu_op=ADD, ex_alu_src=1, ex_reg_we=1.
- Bypass: rd1=32'h11, with wb_we=1, wb_wa=ra1=7, wb_wd=32'h22 → ex_rs1_val=32'h22. Repeat with wb_wa=0 or ra1=0 → 32'h11 or 0 respectively.
- Load-use:
  - lw x6,0(x1), then add x7,x6,x2 → stall=1 for exactly one cycle, with ex_valid=0 bubble.
  - Next cycle: add enters EX with ex_rs1=6.
  - Same sequence with rd=x0 or with LUI as consumer → no stall.
- Flush precedence: load-use condition and ex_flush=1 in the same cycle → stall=0, next ex_valid=0.
- Async reset mid-stream: assert rst between clock edges → ex_valid=0 and ex_pc=RESET_PC immediately; illegal opcode 32'h0000007F → ex_valid=0.
- With ID_STALL_CNT_EN: 3 separate load-use hazards → stall_cnt=3. Preload 32'hFFFFFFFF, then one more stall → stall_cnt=0.
